keypad_replayer: RTL and testbench
==================================

# keypad_replayer

Keypad-matrix emulator that plays back queued keycodes onto the 4x4 keypad interface, acting as the switch-matrix end of the column-scan protocol. A producer (test sequencer, UART command decoder or self-test ROM) pushes 4-bit keycodes through a valid/ready port. The block drives the row lines exactly as a physical keypad would for each key: pressed for a fixed hold time, then released for a fixed gap. The keypad scanner and keycode encoder attach unchanged. Used for hardware self-test of the calculator and for closed-loop simulation.

## Interface
- HOLD_CYCLES, 240000, cycles a key stays pressed (20 ms at 12 MHz); must be >= 1
- GAP_CYCLES, 240000, release cycles after each key before the next press; must be >= 1
- Clk  in  1  system clock (12 MHz on board)
- reset  in  1  asynchronous, active-low
- flush  in  1  synchronous; empties the queue and aborts any press
- key_valid  in  1  producer offers key_code this cycle
- key_code  in  4  keycode 0x0-0xF, same encoding the keypad encoder outputs
- key_ready  out  1  queue can accept; equals not-full
- col_in  in  4  column drive from the scanner, active-low; col_in[c] is column c, c=0 leftmost
- row_out  out  4  row lines to the scanner, active-low, idle high; row_out[r] is row r, r=0 top
- pressing  out  1  high while a key is held
- busy  out  1  high when the queue is non-empty or state is not IDLE
- keys_sent  out  8  count of completed presses, wraps 255 -> 0

## Operation
- Keymap (row r, columns 0..3): r0 = 1 2 3 A; r1 = 4 5 6 B; r2 = 7 8 9 C; r3 = 0 F E D. The key-to-(row, col) lookup is combinational on the latched code.
- Queue: 4-entry FIFO. Push occurs when key_valid && key_ready. key_ready = !full. When the queue is full, a push is refused even if a pop occurs in the same cycle. Codes are played strictly in push order.
- FSM states: IDLE, PRESS, GAP.
  - IDLE: if the queue is non-empty, pop the head into cur_code, clear the counter, and go to PRESS. Otherwise stay in IDLE.
  - PRESS: the counter counts 0..HOLD_CYCLES-1. On the last count, go to GAP, clear the counter, and increment keys_sent.
  - GAP: the counter counts 0..GAP_CYCLES-1. On the last count, go to IDLE.
- Row drive is combinational: row_out[r] = 0 iff state == PRESS, r == row(cur_code), and col_in[col(cur_code)] == 0. Otherwise the line is 1. The col_in -> row_out path is purely combinational, like a closed switch; no register is allowed in this path.
- pressing = (state == PRESS). busy = (state != IDLE) || !empty.
- flush has priority over all other activity. It resets the FIFO pointers and count to empty and moves the FSM to IDLE. keys_sent is unchanged. Any push offered in the same cycle is discarded.
- Counter width is sized for max(HOLD_CYCLES, GAP_CYCLES). The counter must not wrap within a state.

## Timing
- Reset values (asynchronous): state IDLE, FIFO empty, row_out 4'hF, pressing 0, busy 0, keys_sent 0, key_ready 1.
- Push accepted at edge N into an empty queue with the FSM in IDLE:
  - busy = 1 after edge N.
  - PRESS is entered at edge N+1; pressing is high for exactly HOLD_CYCLES cycles.
  - GAP lasts exactly GAP_CYCLES cycles.
  - IDLE is re-entered at edge N+1+HOLD_CYCLES+GAP_CYCLES.
- Back-to-back keys: each key occupies 1 + HOLD_CYCLES + GAP_CYCLES cycles, including one IDLE cycle between keys.
- keys_sent updates on the PRESS -> GAP edge.
- A push into a non-empty or full queue does not change the in-progress press.
- Reset or flush during PRESS: row_out returns to 4'hF in the same cycle (reset) or after the next edge (flush).

## Test plan
- Single key, HOLD=8, GAP=4: push 0x5 with a scanner model driving col_in one-hot-low rotating every 2 cycles. Required response:
  - row_out[1] = 0 only when col_in[1] = 0, for 8 cycles.
  - keys_sent = 1; busy drops 13 cycles after the push.
  - The encoder sees 0x5.
- Full keymap: push 0x0-0xF in order, refilling as key_ready allows. Required response:
  - Each key asserts exactly its (row, col) from the keymap.
  - Sixteen presses total; keys_sent = 16.
- Backpressure: hold key_valid high with 6 distinct codes. Required response:
  - key_ready deasserts after 4 entries are queued.
  - No code is lost or duplicated; the output order equals the push order.
  - A push attempted while full and popping is refused.
- Flush mid-press: push 0x1, 0x2, 0x3; assert flush 3 cycles into the first PRESS. Required response:
  - row_out = 4'hF and the FSM is in IDLE after the next edge.
  - busy = 0; keys_sent = 0; no further presses occur.
- Async reset mid-GAP: row_out = 4'hF immediately and all outputs are at their reset values. After release, push 0xD; the D press completes normally with keys_sent = 1.
- keys_sent wrap: run 256 presses (HOLD=1, GAP=1). keys_sent reads 0 after the 256th press and 1 after the 257th.

Source files
------------

// File: rtl/keypad_replayer.sv
// Keypad-matrix emulator: replays queued 4-bit keycodes as timed presses on a 4x4 row/column matrix.
// Latency: a code pushed into an empty queue with the FSM idle is pressed from the next edge; row_out follows col_in combinationally.
// Backpressure: key_ready = !full of a 4-entry queue; a full queue refuses pushes even when it pops in the same cycle.

module kr_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_dat_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic             push_ok, pop_ok;

    assign full_o    = (cnt_q == FULL_CNT);
    assign empty_o   = (cnt_q == '0);
    assign push_ok   = push_i && !full_o && !clr_i;
    assign pop_ok    = pop_i && !empty_o && !clr_i;
    assign pop_dat_o = mem_q[rd_ptr_q];

    always_ff @(posedge Clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + (AW + 1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW + 1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

module keypad_replayer #(
    parameter int HOLD_CYCLES = 240000,
    parameter int GAP_CYCLES  = 240000
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_ready,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic       pressing,
    output logic       busy,
    output logic [7:0] keys_sent
);
    localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t      state_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]  cur_code_q;
    logic        pressing_q;
    logic [7:0]  keys_sent_q;

    logic        fifo_full, fifo_empty, fifo_pop;
    logic [3:0]  fifo_dat;
    logic [1:0]  key_row, key_col;

    assign fifo_pop = (state_q == IDLE) && !fifo_empty && !flush;

    kr_fifo #(.WIDTH(4), .DEPTH(4)) u_fifo (
        .Clk        (Clk),
        .reset      (reset),
        .clr_i      (flush),
        .push_i     (key_valid),
        .push_dat_i (key_code),
        .pop_i      (fifo_pop),
        .pop_dat_o  (fifo_dat),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cur_code_q  <= '0;
            pressing_q  <= 1'b0;
            keys_sent_q <= '0;
        end else if (flush) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pressing_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        cur_code_q <= fifo_dat;
                        cnt_q      <= '0;
                        pressing_q <= 1'b1;
                        state_q    <= PRESS;
                    end
                end
                PRESS: begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_q       <= '0;
                        pressing_q  <= 1'b0;
                        keys_sent_q <= keys_sent_q + 8'd1;
                        state_q     <= GAP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    cnt_q      <= '0;
                    pressing_q <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    // Physical keymap: r0 = 1 2 3 A, r1 = 4 5 6 B, r2 = 7 8 9 C, r3 = 0 F E D
    always_comb begin
        key_row = 2'd0;
        key_col = 2'd0;
        case (cur_code_q)
            4'h1: begin key_row = 2'd0; key_col = 2'd0; end
            4'h2: begin key_row = 2'd0; key_col = 2'd1; end
            4'h3: begin key_row = 2'd0; key_col = 2'd2; end
            4'hA: begin key_row = 2'd0; key_col = 2'd3; end
            4'h4: begin key_row = 2'd1; key_col = 2'd0; end
            4'h5: begin key_row = 2'd1; key_col = 2'd1; end
            4'h6: begin key_row = 2'd1; key_col = 2'd2; end
            4'hB: begin key_row = 2'd1; key_col = 2'd3; end
            4'h7: begin key_row = 2'd2; key_col = 2'd0; end
            4'h8: begin key_row = 2'd2; key_col = 2'd1; end
            4'h9: begin key_row = 2'd2; key_col = 2'd2; end
            4'hC: begin key_row = 2'd2; key_col = 2'd3; end
            4'h0: begin key_row = 2'd3; key_col = 2'd0; end
            4'hF: begin key_row = 2'd3; key_col = 2'd1; end
            4'hE: begin key_row = 2'd3; key_col = 2'd2; end
            4'hD: begin key_row = 2'd3; key_col = 2'd3; end
            default: begin key_row = 2'd0; key_col = 2'd0; end
        endcase
    end

    // Behaves like a closed switch: the column drive reaches the row line with no register in between.
    always_comb begin
        row_out = 4'hF;
        if ((state_q == PRESS) && !col_in[key_col]) begin
            row_out[key_row] = 1'b0;
        end
    end

    assign key_ready = !fifo_full;
    assign pressing  = pressing_q;
    assign busy      = (state_q != IDLE) || !fifo_empty;
    assign keys_sent = keys_sent_q;
endmodule

// File: tb/tb_keypad_replayer.sv
// Scoreboard bench for keypad_replayer: accepted pushes queue expected codes, a monitor checks each press.
module tb_keypad_replayer;
    localparam int HOLD = 8;
    localparam int GAP  = 4;

    logic       Clk = 1'b0;
    logic       reset = 1'b0;
    logic       flush = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic       key_ready;
    logic [3:0] col_in = 4'hF;
    logic [3:0] row_out;
    logic       pressing;
    logic       busy;
    logic [7:0] keys_sent;

    logic       key_valid_w = 1'b0;
    logic [3:0] key_code_w = 4'h4;
    logic       flush_w = 1'b0;
    logic [3:0] col_in_w = 4'hF;
    logic       key_ready_w;
    logic [3:0] row_out_w;
    logic       pressing_w;
    logic       busy_w;
    logic [7:0] keys_sent_w;

    keypad_replayer #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
        .Clk(Clk), .reset(reset), .flush(flush), .key_valid(key_valid), .key_code(key_code),
        .key_ready(key_ready), .col_in(col_in), .row_out(row_out), .pressing(pressing),
        .busy(busy), .keys_sent(keys_sent)
    );

    keypad_replayer #(.HOLD_CYCLES(1), .GAP_CYCLES(1)) dut_w (
        .Clk(Clk), .reset(reset), .flush(flush_w), .key_valid(key_valid_w), .key_code(key_code_w),
        .key_ready(key_ready_w), .col_in(col_in_w), .row_out(row_out_w), .pressing(pressing_w),
        .busy(busy_w), .keys_sent(keys_sent_w)
    );

    logic [3:0] km [4][4] = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                              '{4'h4, 4'h5, 4'h6, 4'hB},
                              '{4'h7, 4'h8, 4'h9, 4'hC},
                              '{4'h0, 4'hF, 4'hE, 4'hD}};

    logic [3:0] exp_q [$];
    int  n_chk = 0;
    int  n_pass = 0;
    int  exp_sent = 0;
    int  n_press = 0;
    int  cyc = 0;
    bit  abort = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    function automatic logic [3:0] expected_rows(input logic [3:0] code, input logic [3:0] cols);
        logic [3:0] rows;
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (km[r][c] == code && !cols[c]) rows[r] = 1'b0;
        return rows;
    endfunction

    initial forever #5 Clk = ~Clk;
    initial forever begin @(posedge Clk); cyc++; end

    // Scanner: one column driven low at a time, advancing every 2 cycles.
    initial begin
        int sel;
        sel = 0;
        forever begin
            repeat (2) @(posedge Clk);
            #1;
            col_in = ~(4'b0001 << sel);
            sel = (sel + 1) % 4;
        end
    end

    // Monitor / scoreboard
    initial begin
        bit         in_press;
        bit         bad;
        int         len;
        logic [4:0] dec;
        logic [3:0] ex;
        in_press = 1'b0; bad = 1'b0; len = 0; dec = 5'h10;
        forever begin
            @(negedge Clk);
            if (!reset) begin
                in_press = 1'b0;
            end else if (pressing) begin
                if (!in_press) begin
                    in_press = 1'b1; len = 0; bad = 1'b0; dec = 5'h10;
                end
                len++;
                if (!abort && exp_q.size() > 0)
                    if (row_out !== expected_rows(exp_q[0], col_in)) bad = 1'b1;
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++)
                        if (!row_out[r] && !col_in[c]) dec = {1'b0, km[r][c]};
            end else if (in_press) begin
                in_press = 1'b0;
                if (abort) begin
                    abort = 1'b0;
                end else if (exp_q.size() == 0) begin
                    check("spurious_press", 32'd1, 32'd0);
                end else begin
                    ex = exp_q.pop_front();
                    n_press++;
                    exp_sent++;
                    check("row_drive", {31'd0, bad}, 32'd0);
                    check("encoder_code", {27'd0, dec}, {28'd0, ex});
                    check("hold_len", len, HOLD);
                    check("keys_sent", {24'd0, keys_sent}, exp_sent % 256);
                end
            end
        end
    end

    task automatic push_key(input logic [3:0] c, output int acc_cyc, output int waited);
        key_valid = 1'b1;
        key_code  = c;
        waited    = 0;
        while (!key_ready && waited < 200) begin
            @(negedge Clk);
            waited++;
        end
        if (!key_ready) begin
            check("push_timeout", 32'd1, 32'd0);
            acc_cyc = -1;
        end else begin
            @(posedge Clk);
            exp_q.push_back(c);
            @(negedge Clk);
            acc_cyc = cyc;
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 1000) begin
            @(negedge Clk);
            n++;
        end
        check({name, "_idle"}, {31'd0, busy}, 32'd0);
        check({name, "_drain"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        int acc [6];
        int w, n, n0, nfall;
        logic [3:0] bp_codes [6];
        bit prev_w;

        bp_codes = '{4'h9, 4'hA, 4'hB, 4'hC, 4'hE, 4'hF};

        #12;
        check("rst_row", {28'd0, row_out}, 32'hF);
        check("rst_pressing", {31'd0, pressing}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_keys_sent", {24'd0, keys_sent}, 32'd0);
        check("rst_ready", {31'd0, key_ready}, 32'd1);
        @(negedge Clk);
        reset = 1'b1;
        repeat (2) @(negedge Clk);

        // Single key: busy 13 cycles
        push_key(4'h5, acc[0], w);
        key_valid = 1'b0;
        check("busy_after_push", {31'd0, busy}, 32'd1);
        n = 0;
        while (busy && n < 100) begin
            @(negedge Clk);
            n++;
        end
        check("busy_drop_cycles", n, 13);
        check("single_keys_sent", {24'd0, keys_sent}, 32'd1);
        wait_idle("single");

        // Full keymap
        n0 = n_press;
        for (int k = 0; k < 16; k++) push_key(4'(k), acc[0], w);
        key_valid = 1'b0;
        wait_idle("keymap");
        check("keymap_presses", n_press - n0, 16);
        check("keymap_keys_sent", {24'd0, keys_sent}, 32'd17);

        // Backpressure: valid held across six codes
        for (int k = 0; k < 6; k++) begin
            push_key(bp_codes[k], acc[k], w);
            if (k == 4) check("ready_low_when_full", {31'd0, key_ready}, 32'd0);
            if (k < 5) check("no_stall_before_full", w, 0);
        end
        key_valid = 1'b0;
        check("full_pop_refused_timing", acc[5] - acc[0], 15);
        wait_idle("backpressure");
        check("bp_keys_sent", {24'd0, keys_sent}, 32'd23);

        // Flush mid-press
        push_key(4'h1, acc[0], w);
        push_key(4'h2, acc[1], w);
        push_key(4'h3, acc[2], w);
        key_valid = 1'b0;
        @(negedge Clk);
        check("flush_pre_pressing", {31'd0, pressing}, 32'd1);
        flush = 1'b1;
        abort = 1'b1;
        exp_q.delete();
        @(negedge Clk);
        flush = 1'b0;
        check("flush_row", {28'd0, row_out}, 32'hF);
        check("flush_pressing", {31'd0, pressing}, 32'd0);
        check("flush_busy", {31'd0, busy}, 32'd0);
        n = 0;
        repeat (40) begin
            @(negedge Clk);
            if (pressing || busy) n++;
        end
        check("flush_no_more_press", n, 0);
        check("flush_keys_sent", {24'd0, keys_sent}, 32'd23);

        // Async reset mid-GAP
        push_key(4'h7, acc[0], w);
        key_valid = 1'b0;
        n = 0;
        while (!pressing && n < 50) begin @(negedge Clk); n++; end
        while (pressing && n < 100) begin @(negedge Clk); n++; end
        @(negedge Clk);
        check("pre_reset_in_gap", {31'd0, busy}, 32'd1);
        #2;
        reset = 1'b0;
        exp_sent = 0;
        #1;
        check("arst_row", {28'd0, row_out}, 32'hF);
        check("arst_pressing", {31'd0, pressing}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_keys_sent", {24'd0, keys_sent}, 32'd0);
        check("arst_ready", {31'd0, key_ready}, 32'd1);
        @(negedge Clk);
        reset = 1'b1;
        @(negedge Clk);
        push_key(4'hD, acc[0], w);
        key_valid = 1'b0;
        wait_idle("after_reset");
        check("after_reset_keys_sent", {24'd0, keys_sent}, 32'd1);

        // keys_sent wrap on the HOLD=1/GAP=1 instance
        key_valid_w = 1'b1;
        nfall = 0;
        prev_w = 1'b0;
        for (int i = 0; i < 3000 && nfall < 257; i++) begin
            @(negedge Clk);
            if (prev_w && !pressing_w) begin
                nfall++;
                if (nfall == 1)   check("wrap_first", {24'd0, keys_sent_w}, 32'd1);
                if (nfall == 255) check("wrap_255", {24'd0, keys_sent_w}, 32'd255);
                if (nfall == 256) check("wrap_256", {24'd0, keys_sent_w}, 32'd0);
                if (nfall == 257) check("wrap_257", {24'd0, keys_sent_w}, 32'd1);
            end
            prev_w = pressing_w;
        end
        key_valid_w = 1'b0;
        check("wrap_press_count", nfall, 257);
        repeat (40) @(negedge Clk);
        check("wrap_busy_end", {31'd0, busy_w}, 32'd0);
        check("wrap_ready_end", {31'd0, key_ready_w}, 32'd1);
        check("wrap_row_idle", {28'd0, row_out_w}, 32'hF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_chk);
        $fatal(1);
    end
endmodule
